// File: rtl/game_select_pkg.sv
// Shared types and constants for the game-selection controller.
// Start patterns, state encoding and LFSR constants for GAME_SELECT_RANDOM_EN.
package game_select_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREVIEW,
    LOADING,
    LOCKED
  } state_e;

  localparam int MAX_GAMES = 8;
  localparam int MAX_COLS  = 8;
  localparam int PAT_W     = 7;

  typedef logic [PAT_W-1:0] pat_t;

  // Row = game, entry = column (col1 first); unused slots stay dark.
  localparam pat_t GAME_PATTERNS [MAX_GAMES][MAX_COLS] = '{
    '{7'b0111100, 7'b0011101, 7'b0110101, 7'b1000111,
      7'b1110111, 7'b0000000, 7'b0000000, 7'b0000000},
    '{7'b0001101, 7'b1011100, 7'b1011101, 7'b1110111,
      7'b1000111, 7'b0000000, 7'b0000000, 7'b0000000},
    '{default: 7'b0000000},
    '{default: 7'b0000000},
    '{default: 7'b0000000},
    '{default: 7'b0000000},
    '{default: 7'b0000000},
    '{default: 7'b0000000}
  };

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // x^8 + x^6 + x^5 + x^4 + 1 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_select_ctrl_rom.sv
// Combinational start-pattern lookup: (game, column) -> column word.
// Columns beyond the stored table width read as zero.
module game_pattern_rom
  import game_select_pkg::*;
#(
  parameter int GW    = 2,
  parameter int CW    = 3,
  parameter int COL_H = 7
) (
  input  logic [GW-1:0]    game_i,
  input  logic [CW-1:0]    col_i,
  output logic [COL_H-1:0] word_o
);

  logic [2:0] g3;
  logic [2:0] c3;

  always_comb begin
    word_o = '0;
    g3     = 3'(game_i);
    c3     = 3'(col_i);
    if (32'(col_i) < MAX_COLS) begin
      word_o = COL_H'(GAME_PATTERNS[g3][c3]);
    end
  end

endmodule

// File: rtl/game_select_ctrl.sv
// Game selection controller: previews, loads and locks a start pattern.
// Optional random pick in IDLE when GAME_SELECT_RANDOM_EN is defined.
module game_select_ctrl
  import game_select_pkg::*;
#(
  parameter int NUM_GAMES = 4,
  parameter int NUM_COLS  = 5,
  parameter int COL_H     = 7,
  localparam int GW = $clog2(NUM_GAMES),
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      select_game,
  input  logic [NUM_GAMES-1:0]      game_option,
  output logic [NUM_COLS*COL_H-1:0] cols_out,
  output logic                      game_locked,
  output logic [GW-1:0]             game_index,
  output logic                      load_busy,
  output logic                      invalid_option
);

  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

  state_e                    state_q, state_d;
  logic                      sel_q;
  logic [CW-1:0]             sp_q, sp_d;
  logic [CW-1:0]             lp_q, lp_d;
  logic [GW-1:0]             lk_q, lk_d;
  logic [NUM_COLS*COL_H-1:0] cols_q, cols_d;
  logic                      inv_q;

  logic                      sel_edge;
  logic                      option_valid;
  logic                      option_nz;
  logic [GW-1:0]             opt_idx;
  logic [GW-1:0]             rom_game;
  logic [CW-1:0]             rom_col;
  logic [COL_H-1:0]          rom_word;

`ifdef GAME_SELECT_RANDOM_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end
`endif

  assign sel_edge  = select_game & ~sel_q;
  assign option_nz = |game_option;
  assign option_valid = option_nz &&
    ((game_option & (game_option - NUM_GAMES'(1))) == '0);

  always_comb begin
    opt_idx = '0;
    for (int i = 0; i < NUM_GAMES; i++) begin
      if (game_option[i]) opt_idx = GW'(i);
    end
  end

  // One shared ROM port: loading reads the latched game, preview the live one.
  assign rom_game = (state_q == LOADING) ? lk_q : opt_idx;
  assign rom_col  = (state_q == LOADING) ? lp_q : sp_q;

  game_pattern_rom #(
    .GW    (GW),
    .CW    (CW),
    .COL_H (COL_H)
  ) u_rom (
    .game_i (rom_game),
    .col_i  (rom_col),
    .word_o (rom_word)
  );

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    lp_d    = lp_q;
    lk_d    = lk_q;
    cols_d  = cols_q;
    unique case (state_q)
      IDLE: begin
        cols_d = '0;
        if (option_valid) begin
          state_d = PREVIEW;
`ifdef GAME_SELECT_RANDOM_EN
        end else if (sel_edge && !option_nz) begin
          state_d = LOADING;
          lk_d    = lfsr_q[GW-1:0];
          lp_d    = '0;
`endif
        end
      end
      PREVIEW: begin
        if (!option_valid) begin
          state_d = IDLE;
          cols_d  = '0;
        end else begin
          cols_d[rom_col*COL_H +: COL_H] = rom_word;
          sp_d = (sp_q == LAST_COL) ? '0 : sp_q + CW'(1);
          if (sel_edge) begin
            state_d = LOADING;
            lk_d    = opt_idx;
            lp_d    = '0;
          end
        end
      end
      LOADING: begin
        cols_d[rom_col*COL_H +: COL_H] = rom_word;
        if (lp_q == LAST_COL) state_d = LOCKED;
        else                  lp_d = lp_q + CW'(1);
      end
      LOCKED: begin
        if (sel_edge) begin
          if (option_valid) begin
            state_d = PREVIEW;
          end else begin
            state_d = IDLE;
            cols_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      sp_q    <= '0;
      lp_q    <= '0;
      lk_q    <= '0;
      cols_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= select_game;
      sp_q    <= sp_d;
      lp_q    <= lp_d;
      lk_q    <= lk_d;
      cols_q  <= cols_d;
      inv_q   <= option_nz & ~option_valid;
    end
  end

  assign cols_out       = cols_q;
  assign game_locked    = (state_q == LOCKED);
  assign load_busy      = (state_q == LOADING);
  assign game_index     = (state_q == LOCKED) ? lk_q : '0;
  assign invalid_option = inv_q;

endmodule

// File: tb/tb_game_select_ctrl.sv
// Scoreboard bench for game_select_ctrl (default 4 games, 5x7 frame).
// Random-pick scenario runs only when GAME_SELECT_RANDOM_EN is defined.
module tb_game_select_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        select_game = 1'b0;
  logic [3:0]  game_option = 4'b0;
  logic [34:0] cols_out;
  logic        game_locked;
  logic [1:0]  game_index;
  logic        load_busy;
  logic        invalid_option;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] pat0 [5] = '{7'b0111100, 7'b0011101, 7'b0110101,
                           7'b1000111, 7'b1110111};
  logic [6:0] pat1 [5] = '{7'b0001101, 7'b1011100, 7'b1011101,
                           7'b1110111, 7'b1000111};

  game_select_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .select_game    (select_game),
    .game_option    (game_option),
    .cols_out       (cols_out),
    .game_locked    (game_locked),
    .game_index     (game_index),
    .load_busy      (load_busy),
    .invalid_option (invalid_option)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 1, steps every cycle.
  logic [7:0] ref_lfsr;
  always @(posedge clk) begin
    if (reset) ref_lfsr <= 8'h01;
    else ref_lfsr <= {ref_lfsr[6:0],
                      ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  end

  function automatic logic [34:0] frame_of(int g);
    logic [34:0] f;
    f = '0;
    for (int c = 0; c < 5; c++) begin
      if (g == 0) f[c*7 +: 7] = pat0[c];
      if (g == 1) f[c*7 +: 7] = pat1[c];
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [63:0] v);
    exp_t x;
    x.name = n;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic wait_frame(input logic [34:0] f, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cols_out === f) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    select_game = 1'b0;
    game_option = 4'b0;
    tick();
    tick();
    push("rst_cols", 64'd0);
    push("rst_locked", 64'd0);
    push("rst_index", 64'd0);
    push("rst_busy", 64'd0);
    push("rst_invalid", 64'd0);
    e = sb.pop_front(); checks++;
    if (64'(cols_out) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, cols_out, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_locked) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_locked, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_index) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_index, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(load_busy) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, load_busy, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(invalid_option) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, invalid_option, e.val);
    end
    reset = 1'b0;
  endtask

  task automatic test_preview();
    game_option = 4'b0001;
    push("preview_frame0", 64'(frame_of(0)));
    push("preview_unlocked", 64'd0);
    wait_frame(frame_of(0), 7);
    e = sb.pop_front(); checks++;
    if (64'(cols_out) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, cols_out, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_locked) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_locked, e.val);
    end
  endtask

  task automatic test_lock();
    int busy_cnt;
    int lock_at;
    game_option = 4'b0010;
    wait_frame(frame_of(1), 7);
    busy_cnt = 0;
    lock_at  = 0;
    select_game = 1'b1;
    push("lock_busy_cycles", 64'd5);
    push("lock_latency", 64'd6);
    push("lock_index", 64'd1);
    push("lock_frame1", 64'(frame_of(1)));
    push("lock_held_no_unlock", 64'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (load_busy) busy_cnt++;
      if (game_locked && lock_at == 0) lock_at = i;
    end
    e = sb.pop_front(); checks++;
    if (64'(busy_cnt) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(lock_at) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name, lock_at, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_index) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_index, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(cols_out) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, cols_out, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_locked) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_locked, e.val);
    end
  endtask

  task automatic test_locked_unlock();
    game_option = 4'b0001;
    push("locked_frame_frozen", 64'(frame_of(1)));
    push("locked_index_kept", 64'd1);
    tick(); tick(); tick();
    e = sb.pop_front(); checks++;
    if (64'(cols_out) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, cols_out, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_index) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_index, e.val);
    end
    select_game = 1'b0;
    tick();
    select_game = 1'b1;
    push("unlock_frame0", 64'(frame_of(0)));
    push("unlock_unlocked", 64'd0);
    tick();
    wait_frame(frame_of(0), 6);
    e = sb.pop_front(); checks++;
    if (64'(cols_out) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, cols_out, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_locked) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_locked, e.val);
    end
  endtask

  task automatic test_invalid();
    select_game = 1'b0;
    tick();
    game_option = 4'b0011;
    push("invalid_cols", 64'd0);
    push("invalid_flag", 64'd1);
    tick();
    e = sb.pop_front(); checks++;
    if (64'(cols_out) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, cols_out, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(invalid_option) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, invalid_option, e.val);
    end
    select_game = 1'b1;
    push("idle_sel_busy", 64'd0);
    push("idle_sel_locked", 64'd0);
    push("idle_sel_cols", 64'd0);
    tick(); tick(); tick();
    e = sb.pop_front(); checks++;
    if (64'(load_busy) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, load_busy, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_locked) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_locked, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(cols_out) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, cols_out, e.val);
    end
    select_game = 1'b0;
    tick();
  endtask

  task automatic test_reset_loading();
    int n;
    game_option = 4'b0001;
    tick();
    tick();
    select_game = 1'b1;
    n = 0;
    push("rl_reached_3rd", 64'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (load_busy) n++;
      if (n == 3) break;
    end
    e = sb.pop_front(); checks++;
    if (64'(n) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
    reset = 1'b1;
    push("rl_busy", 64'd0);
    push("rl_locked", 64'd0);
    push("rl_cols", 64'd0);
    tick();
    reset = 1'b0;
    select_game = 1'b0;
    e = sb.pop_front(); checks++;
    if (64'(load_busy) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, load_busy, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_locked) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_locked, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(cols_out) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, cols_out, e.val);
    end
  endtask

`ifdef GAME_SELECT_RANDOM_EN
  task automatic test_random();
    int waited;
    reset = 1'b1;
    select_game = 1'b0;
    game_option = 4'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    select_game = 1'b1;
    push("random_index", 64'(ref_lfsr[1:0]));
    push("random_locked", 64'd1);
    waited = 0;
    while (!game_locked && waited < 12) begin
      tick();
      waited++;
    end
    e = sb.pop_front(); checks++;
    if (64'(game_index) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_index, e.val);
    end
    e = sb.pop_front(); checks++;
    if (64'(game_locked) !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, game_locked, e.val);
    end
    select_game = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_preview();
    test_lock();
    test_locked_unlock();
    test_invalid();
    test_reset_loading();
`ifdef GAME_SELECT_RANDOM_EN
    test_random();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_select_ctrl.md
Name: game_select_ctrl

Overview:
- Clocked, parametrised successor to the game-selection logic for the LED-matrix game board.
- Picks one of NUM_GAMES stored start patterns from a one-hot option switch bank and previews it on the column bus.
- Locks and unlocks the choice on select-button edges.
- Feeds the column-scan driver that multiplexes the matrix.

Parameters:
NUM_GAMES, 4, number of selectable games; option width; must be a power of two, 2..8
NUM_COLS, 5, matrix columns per frame
COL_H, 7, LEDs per column (bits per column word)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clears state, columns, lock
select_game  in  1  synchronised level from lock/unlock button; edge-detected internally
game_option  in  NUM_GAMES  one-hot game choice switches
cols_out  out  NUM_COLS*COL_H  frame; column c at bits [c*COL_H +: COL_H], column 0 = col1
game_locked  out  1  high in LOCKED
game_index  out  $clog2(NUM_GAMES)  index of the locked game; 0 when unlocked
load_busy  out  1  high in LOADING
invalid_option  out  1  high when game_option is nonzero and not one-hot

Behaviour:
- Reset (sync, active-high) sets:
  - state = IDLE
  - cols_out = 0, game_locked = 0, game_index = 0, load_busy = 0
  - edge register = 0, scan pointer = 0
  - invalid_option is registered and also resets to 0.
- Edge detect: sel_q <= select_game every cycle. sel_edge = select_game & ~sel_q. A held button produces exactly one edge.
- option_valid = game_option is exactly one-hot; opt_idx = position of its set bit.
- States:
  - IDLE:
    - cols_out held at 0.
    - option_valid -> PREVIEW next cycle.
    - sel_edge ignored.
  - PREVIEW:
    - Free-running scan pointer sp (0..NUM_COLS-1, wraps) writes column sp from ROM(opt_idx, sp) each cycle.
    - After an option change, the frame is fully correct within NUM_COLS cycles; stale columns in between are permitted.
    - !option_valid -> IDLE, and cols_out cleared in the same transition.
    - sel_edge -> LOADING: latch lk_idx = opt_idx and reset the load pointer to 0.
    - If both occur in one cycle, invalidity wins.
  - LOADING:
    - Writes column lp from ROM(lk_idx, lp), one column per cycle, lp = 0..NUM_COLS-1.
    - After the last column -> LOCKED.
    - game_option and sel_edge are ignored.
    - game_locked rises NUM_COLS+1 clocks after the clock that sampled the edge.
  - LOCKED:
    - cols_out frozen; game_index = lk_idx; game_option changes ignored.
    - sel_edge -> PREVIEW if option_valid, else IDLE (cols_out cleared).
- Reset mid-LOADING or in LOCKED: returns to IDLE next clock; partial frame discarded.
- ROM contents, column words col1..col5, MSB first:
  - game 0: 0111100, 0011101, 0110101, 1000111, 1110111
  - game 1: 0001101, 1011100, 1011101, 1110111, 1000111
  - games 2..7: all-zero until the package defines them
  - Columns at or beyond the table width read as 0.

Optional Feature:
- Macro: GAME_SELECT_RANDOM_EN.
- When defined:
  - An 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'h01 on reset, steps every cycle.
  - sel_edge in IDLE with game_option == 0 enters LOADING with lk_idx = lfsr[$clog2(NUM_GAMES)-1:0].
- When undefined: no LFSR exists; sel_edge in IDLE is ignored.

Decomposition:
- Package game_select_pkg holds:
  - state enum {IDLE, PREVIEW, LOADING, LOCKED}
  - MAX_GAMES = 8, MAX_COLS = 8
  - GAME_PATTERNS constant array [MAX_GAMES][MAX_COLS] of 7-bit words
  - LFSR seed and tap constants
- One sub-module, game_pattern_rom: combinational (game index, column index) -> COL_H-bit word, sourced from the package constant.

Test Plan:
- Reset then game_option = 4'b0001 -> IDLE to PREVIEW; within 6 cycles cols_out[6:0] = 0111100 and cols_out[34:28] = 1110111; game_locked = 0.
- Lock latency and freeze:
  - In PREVIEW with option 4'b0010, hold select_game high for 10 cycles.
  - Required: load_busy high exactly 5 cycles; game_locked rises 6 clocks after the edge; game_index = 1; frame equals game 1.
  - Only one edge is counted; no unlock occurs.
- While LOCKED, switch option to 4'b0001 -> frame unchanged. Then give a select edge -> PREVIEW; frame converges to game 0 within 5 cycles.
- game_option = 4'b0011 in PREVIEW -> next cycle IDLE, cols_out = 0, invalid_option = 1. A select edge then -> no state change (macro off).
- Assert reset on the 3rd LOADING cycle -> next clock: IDLE, cols_out = 0, load_busy = 0, game_locked = 0.
- With GAME_SELECT_RANDOM_EN: reset, game_option = 0, select edge on cycle k -> locked game_index equals the low 2 bits of the reference LFSR model at cycle k.
